// File: rtl/shift_right_logical.sv
// shift_right_logical
//   Registered logical right shifter. The operand a is shifted right by the
//   unsigned amount b, and the vacated MSBs are filled with zeros. The shift
//   network is a logarithmic barrel shifter: one mux stage per bit of b, with
//   stage k shifting by 2**k. The result is captured in an output register
//   one cycle after in_valid.
//
// Ports
//   clk       : rising-edge clock
//   rst       : synchronous, active-high reset
//   in_valid  : capture a/b on this edge
//   a         : operand, WIDTH bits
//   b         : shift amount, SHAMT_W bits, taken literally (0..2**SHAMT_W-1)
//   out       : registered a >> b
//   out_valid : out was captured on the previous edge
//   zero      : registered "result is all zeros" flag
//               (present only when SRL_ZERO_FLAG_EN is defined)
//
// Build options
//   SRL_ZERO_FLAG_EN : adds the zero output and its flag register.
//
// Parameter constraint: 2**SHAMT_W must not exceed WIDTH.

module shift_right_logical #(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] b,
`ifdef SRL_ZERO_FLAG_EN
  output logic               zero,
`endif
  output logic [WIDTH-1:0]   out,
  output logic               out_valid
);

  logic [WIDTH-1:0] shift_res;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;

  // Barrel network. Each pass either shifts by 2**k or passes the value
  // through, so the total shift equals the binary value of b.
  always_comb begin
    shift_res = a;
    for (int k = 0; k < SHAMT_W; k++) begin
      if (b[k]) begin
        shift_res = shift_res >> (1 << k);
      end
    end
  end

  // The result register loads only on in_valid. An unknown b while idle
  // therefore never reaches out.
  always_comb begin
    out_d       = out_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      out_d       = shift_res;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

`ifdef SRL_ZERO_FLAG_EN
  logic zero_q, zero_d;

  always_comb begin
    zero_d = zero_q;
    if (in_valid) begin
      zero_d = (shift_res == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else begin
      zero_q <= zero_d;
    end
  end

  assign zero = zero_q;
`endif

endmodule

// File: tb/tb_shift_right_logical.sv
module tb_shift_right_logical;

  localparam int WIDTH   = 64;
  localparam int SHAMT_W = 5;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic [WIDTH-1:0]   a;
  logic [SHAMT_W-1:0] b;
  logic [WIDTH-1:0]   out;
  logic               out_valid;
`ifdef SRL_ZERO_FLAG_EN
  logic               zero;
`endif

  int n_assert;
  int n_fail;

  shift_right_logical #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
`ifdef SRL_ZERO_FLAG_EN
    .zero      (zero),
`endif
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;

    // Reset with in_valid asserted: reset must win.
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 64'hFFFF_FFFF_FFFF_FFFF;
    b        = 5'd0;
    tick();
    check("rst1_out", out, 64'h0);
    check("rst1_vld", {63'h0, out_valid}, 64'h0);
`ifdef SRL_ZERO_FLAG_EN
    check("rst1_zero", {63'h0, zero}, 64'h0);
`endif
    tick();
    check("rst2_out", out, 64'h0);
    check("rst2_vld", {63'h0, out_valid}, 64'h0);

    // Back-to-back shifts of a fixed pattern.
    rst = 1'b0;
    a   = 64'hF0F0_F0F0_F0F0_F0F0;
    b   = 5'd0;
    tick();
    check("b0_out", out, 64'hF0F0_F0F0_F0F0_F0F0);
    check("b0_vld", {63'h0, out_valid}, 64'h1);
    b = 5'd1;
    tick();
    check("b1_out", out, 64'h7878_7878_7878_7878);
    check("b1_vld", {63'h0, out_valid}, 64'h1);
    b = 5'd8;
    tick();
    check("b8_out", out, 64'h00F0_F0F0_F0F0_F0F0);
    check("b8_vld", {63'h0, out_valid}, 64'h1);
    b = 5'b10000;
    tick();
    check("b16_out", out, 64'h0000_F0F0_F0F0_F0F0);
    b = 5'b11111;
    tick();
    check("b31_out", out, 64'h0000_0001_E1E1_E1E1);
    check("b31_vld", {63'h0, out_valid}, 64'h1);

    // Capture, then idle with changed inputs (b unknown): out holds.
    b = 5'd4;
    tick();
    check("b4_out", out, 64'h0F0F_0F0F_0F0F_0F0F);
    check("b4_vld", {63'h0, out_valid}, 64'h1);
    in_valid = 1'b0;
    a        = 64'h1234_5678_9ABC_DEF0;
    b        = 'x;
    tick();
    check("idle1_out", out, 64'h0F0F_0F0F_0F0F_0F0F);
    check("idle1_vld", {63'h0, out_valid}, 64'h0);
    tick();
    check("idle2_out", out, 64'h0F0F_0F0F_0F0F_0F0F);

    // Zero fill from the top and the stage-2 path.
    in_valid = 1'b1;
    a        = 64'h8000_0000_0000_0003;
    b        = 5'd2;
    tick();
    check("fill_out", out, 64'h2000_0000_0000_0000);

    // Reset pulse mid-stream while in_valid is high.
    rst = 1'b1;
    a   = 64'hDEAD_BEEF_CAFE_F00D;
    b   = 5'd3;
    tick();
    check("mid_rst_out", out, 64'h0);
    check("mid_rst_vld", {63'h0, out_valid}, 64'h0);
    rst = 1'b0;
    a   = 64'h8000_0000_0000_0000;
    b   = 5'd31;
    tick();
    check("post_rst_out", out, 64'h0000_0001_0000_0000);
    check("post_rst_vld", {63'h0, out_valid}, 64'h1);

    // A reset glitch between edges must have no effect.
    a   = 64'hFFFF_FFFF_FFFF_FFFF;
    b   = 5'd5;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
    check("glitch_out", out, 64'h07FF_FFFF_FFFF_FFFF);
    check("glitch_vld", {63'h0, out_valid}, 64'h1);

`ifdef SRL_ZERO_FLAG_EN
    a = 64'h0000_0000_7FFF_FFFF;
    b = 5'd31;
    tick();
    check("zf31_out", out, 64'h0);
    check("zf31_zero", {63'h0, zero}, 64'h1);
    b = 5'd30;
    tick();
    check("zf30_out", out, 64'h1);
    check("zf30_zero", {63'h0, zero}, 64'h0);
    in_valid = 1'b0;
    a        = 64'h0;
    tick();
    check("zf_hold", {63'h0, zero}, 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
